// File: rtl/rob_unit.sv
// Reorder buffer: hands out rename tags, resolves operands, captures CDB results, commits in order, flushes on mispredict.
// Optional macro ROB_CDB_FWD_EN adds same-cycle CDB forwarding into dispatch operand resolution.
module rob_unit #(
    parameter int ROB_ADD_W = 4,
    parameter int REG_ADD_W = 5,
    parameter int REG_DAT_W = 32,
    parameter int INS_OP_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 iIS_En,
    output logic                 oIS_Full,
    output logic [ROB_ADD_W-1:0] oRF_Qn,
    input  logic                 iRF_En,
    input  logic [ROB_ADD_W-1:0] iRF_Qd,
    input  logic [REG_ADD_W-1:0] iRF_Rd,
    input  logic [ROB_ADD_W-1:0] iRF_Qs1,
    input  logic [ROB_ADD_W-1:0] iRF_Qs2,
    input  logic [REG_DAT_W-1:0] iRF_Vs1,
    input  logic [REG_DAT_W-1:0] iRF_Vs2,
    input  logic [INS_OP_W-1:0]  iRF_Op,
    input  logic [REG_DAT_W-1:0] iRF_Pc,
    input  logic [REG_DAT_W-1:0] iRF_Imm,
    output logic                 oRS_En,
    output logic [ROB_ADD_W-1:0] oRS_Qj,
    output logic [ROB_ADD_W-1:0] oRS_Qk,
    output logic [REG_DAT_W-1:0] oRS_Vj,
    output logic [REG_DAT_W-1:0] oRS_Vk,
    output logic [ROB_ADD_W-1:0] oRS_Qd,
    output logic [INS_OP_W-1:0]  oRS_Op,
    output logic [REG_DAT_W-1:0] oRS_Pc,
    output logic [REG_DAT_W-1:0] oRS_Imm,
    input  logic                 iCDB_En,
    input  logic [ROB_ADD_W-1:0] iCDB_Tag,
    input  logic [REG_DAT_W-1:0] iCDB_Val,
    input  logic                 iCDB_Jmp,
    input  logic [REG_DAT_W-1:0] iCDB_Tgt,
    output logic                 oRF_En,
    output logic [REG_ADD_W-1:0] oRF_Rd,
    output logic [REG_DAT_W-1:0] oRF_Vd,
    output logic                 oMp,
    output logic [REG_DAT_W-1:0] oMp_Pc
);

    localparam int ROB_S = 1 << ROB_ADD_W;
    localparam logic [ROB_ADD_W-1:0] ONE     = ROB_ADD_W'(1);
    localparam logic [ROB_ADD_W-1:0] LAST    = ROB_ADD_W'(ROB_S - 1);
    localparam logic [ROB_ADD_W-1:0] FULL_TH = ROB_ADD_W'(ROB_S - 2);

    logic [ROB_S-1:0]     valid;
    logic [ROB_S-1:0]     filled;
    logic [ROB_S-1:0]     ready;
    logic [ROB_S-1:0]     jmp;
    logic [REG_ADD_W-1:0] rd_q  [ROB_S];
    logic [REG_DAT_W-1:0] val_q [ROB_S];
    logic [REG_DAT_W-1:0] tgt_q [ROB_S];

    logic [ROB_ADD_W-1:0] head;
    logic [ROB_ADD_W-1:0] tail;
    logic [ROB_ADD_W-1:0] count;

    logic                 reserve;
    logic                 commit;
    logic                 flush;
    logic [ROB_ADD_W-1:0] res_qj;
    logic [ROB_ADD_W-1:0] res_qk;
    logic [REG_DAT_W-1:0] res_vj;
    logic [REG_DAT_W-1:0] res_vk;

    // Tag 0 is reserved for "no dependency", so the pointers skip it on wrap.
    function automatic logic [ROB_ADD_W-1:0] next_tag(input logic [ROB_ADD_W-1:0] p);
        return (p == LAST) ? ONE : p + ONE;
    endfunction

    assign oRF_Qn   = rst ? '0 : tail;
    assign oIS_Full = !rst && (count >= FULL_TH);

    assign reserve = iIS_En && (count != LAST);
    assign commit  = valid[head] && filled[head] && ready[head];
    assign flush   = commit && jmp[head];

    always_comb begin
        res_qj = iRF_Qs1;
        res_vj = '0;
        if (iRF_Qs1 == '0) begin
            res_qj = '0;
            res_vj = iRF_Vs1;
        end else if (ready[iRF_Qs1]) begin
            res_qj = '0;
            res_vj = val_q[iRF_Qs1];
        end
`ifdef ROB_CDB_FWD_EN
        else if (iCDB_En && (iCDB_Tag == iRF_Qs1)) begin
            res_qj = '0;
            res_vj = iCDB_Val;
        end
`endif

        res_qk = iRF_Qs2;
        res_vk = '0;
        if (iRF_Qs2 == '0) begin
            res_qk = '0;
            res_vk = iRF_Vs2;
        end else if (ready[iRF_Qs2]) begin
            res_qk = '0;
            res_vk = val_q[iRF_Qs2];
        end
`ifdef ROB_CDB_FWD_EN
        else if (iCDB_En && (iCDB_Tag == iRF_Qs2)) begin
            res_qk = '0;
            res_vk = iCDB_Val;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            filled  <= '0;
            ready   <= '0;
            jmp     <= '0;
            head    <= ONE;
            tail    <= ONE;
            count   <= '0;
            oRS_En  <= 1'b0;
            oRS_Qj  <= '0;
            oRS_Qk  <= '0;
            oRS_Vj  <= '0;
            oRS_Vk  <= '0;
            oRS_Qd  <= '0;
            oRS_Op  <= '0;
            oRS_Pc  <= '0;
            oRS_Imm <= '0;
            oRF_En  <= 1'b0;
            oRF_Rd  <= '0;
            oRF_Vd  <= '0;
            oMp     <= 1'b0;
            oMp_Pc  <= '0;
        end else if (!en) begin
            oRS_En <= 1'b0;
            oRF_En <= 1'b0;
            oMp    <= 1'b0;
        end else begin
            oRS_En <= 1'b0;
            oRF_En <= 1'b0;
            oMp    <= 1'b0;

            if (iRF_En && !flush) begin
                oRS_En  <= 1'b1;
                oRS_Qj  <= res_qj;
                oRS_Qk  <= res_qk;
                oRS_Vj  <= res_vj;
                oRS_Vk  <= res_vk;
                oRS_Qd  <= iRF_Qd;
                oRS_Op  <= iRF_Op;
                oRS_Pc  <= iRF_Pc;
                oRS_Imm <= iRF_Imm;
            end

            if (iCDB_En) begin
                val_q[iCDB_Tag] <= iCDB_Val;
                tgt_q[iCDB_Tag] <= iCDB_Tgt;
                jmp[iCDB_Tag]   <= iCDB_Jmp;
                ready[iCDB_Tag] <= 1'b1;
            end

            if (iRF_En) begin
                rd_q[iRF_Qd]   <= iRF_Rd;
                filled[iRF_Qd] <= 1'b1;
            end

            if (reserve) begin
                valid[tail]  <= 1'b1;
                filled[tail] <= 1'b0;
                ready[tail]  <= 1'b0;
                jmp[tail]    <= 1'b0;
                tail         <= next_tag(tail);
            end

            if (commit) begin
                oRF_En       <= (rd_q[head] != '0);
                oRF_Rd       <= rd_q[head];
                oRF_Vd       <= val_q[head];
                valid[head]  <= 1'b0;
                filled[head] <= 1'b0;
                ready[head]  <= 1'b0;
                jmp[head]    <= 1'b0;
                head         <= next_tag(head);
                if (jmp[head]) begin
                    oMp    <= 1'b1;
                    oMp_Pc <= tgt_q[head];
                end
            end

            case ({reserve, commit})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase

            // Mispredict wins over everything above: the whole window is discarded.
            if (flush) begin
                valid  <= '0;
                filled <= '0;
                ready  <= '0;
                jmp    <= '0;
                head   <= ONE;
                tail   <= ONE;
                count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rob_unit.sv
// Randomized bench for rob_unit: a queue-based reference model predicts every output each cycle.
module tb_rob_unit;

    localparam int AW = 4;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int OW = 6;
    localparam int S  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, en;
    logic          iIS_En, oIS_Full;
    logic [AW-1:0] oRF_Qn;
    logic          iRF_En;
    logic [AW-1:0] iRF_Qd, iRF_Qs1, iRF_Qs2;
    logic [RW-1:0] iRF_Rd;
    logic [DW-1:0] iRF_Vs1, iRF_Vs2, iRF_Pc, iRF_Imm;
    logic [OW-1:0] iRF_Op;
    logic          oRS_En;
    logic [AW-1:0] oRS_Qj, oRS_Qk, oRS_Qd;
    logic [DW-1:0] oRS_Vj, oRS_Vk, oRS_Pc, oRS_Imm;
    logic [OW-1:0] oRS_Op;
    logic          iCDB_En, iCDB_Jmp;
    logic [AW-1:0] iCDB_Tag;
    logic [DW-1:0] iCDB_Val, iCDB_Tgt;
    logic          oRF_En, oMp;
    logic [RW-1:0] oRF_Rd;
    logic [DW-1:0] oRF_Vd, oMp_Pc;

    rob_unit dut (
        .clk(clk), .rst(rst), .en(en),
        .iIS_En(iIS_En), .oIS_Full(oIS_Full), .oRF_Qn(oRF_Qn),
        .iRF_En(iRF_En), .iRF_Qd(iRF_Qd), .iRF_Rd(iRF_Rd),
        .iRF_Qs1(iRF_Qs1), .iRF_Qs2(iRF_Qs2), .iRF_Vs1(iRF_Vs1), .iRF_Vs2(iRF_Vs2),
        .iRF_Op(iRF_Op), .iRF_Pc(iRF_Pc), .iRF_Imm(iRF_Imm),
        .oRS_En(oRS_En), .oRS_Qj(oRS_Qj), .oRS_Qk(oRS_Qk), .oRS_Vj(oRS_Vj), .oRS_Vk(oRS_Vk),
        .oRS_Qd(oRS_Qd), .oRS_Op(oRS_Op), .oRS_Pc(oRS_Pc), .oRS_Imm(oRS_Imm),
        .iCDB_En(iCDB_En), .iCDB_Tag(iCDB_Tag), .iCDB_Val(iCDB_Val),
        .iCDB_Jmp(iCDB_Jmp), .iCDB_Tgt(iCDB_Tgt),
        .oRF_En(oRF_En), .oRF_Rd(oRF_Rd), .oRF_Vd(oRF_Vd),
        .oMp(oMp), .oMp_Pc(oMp_Pc)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: in-order list of live tags plus per-tag entry contents.
    bit            m_filled [S];
    bit            m_ready  [S];
    bit            m_jmp    [S];
    logic [RW-1:0] m_rd     [S];
    logic [DW-1:0] m_val    [S];
    logic [DW-1:0] m_tgt    [S];
    int            q[$];
    int            m_tail;

    logic          e_rs_en, e_rf_en, e_mp;
    logic [AW-1:0] e_qj, e_qk, e_qd;
    logic [DW-1:0] e_vj, e_vk, e_pc, e_imm, e_vd, e_mppc;
    logic [OW-1:0] e_op;
    logic [RW-1:0] e_rd;

    bit            pending_vld;
    logic [AW-1:0] pending_tag;

    function automatic int wrap_next(input int t);
        return (t == S - 1) ? 1 : t + 1;
    endfunction

    function automatic void clear_entry(input int t);
        m_filled[t] = 0;
        m_ready[t]  = 0;
        m_jmp[t]    = 0;
    endfunction

    function automatic bit head_commits();
        return q.size() > 0 && m_filled[q[0]] && m_ready[q[0]];
    endfunction

    task automatic resolve(input logic [AW-1:0] qs, input logic [DW-1:0] vs,
                           output logic [AW-1:0] qo, output logic [DW-1:0] vo);
        qo = qs;
        vo = '0;
        if (qs == 0) begin
            qo = 0; vo = vs;
        end else if (m_ready[qs]) begin
            qo = 0; vo = m_val[qs];
        end
`ifdef ROB_CDB_FWD_EN
        else if (iCDB_En && iCDB_Tag == qs) begin
            qo = 0; vo = iCDB_Val;
        end
`endif
    endtask

    task automatic model_step();
        int  old_cnt, h;
        bit  commit, flush;
        if (rst) begin
            for (int i = 0; i < S; i++) clear_entry(i);
            q.delete();
            m_tail = 1;
            {e_rs_en, e_rf_en, e_mp} = '0;
            {e_qj, e_qk, e_qd, e_vj, e_vk, e_pc, e_imm, e_vd, e_mppc, e_op, e_rd} = '0;
            return;
        end
        e_rs_en = 0; e_rf_en = 0; e_mp = 0;
        if (!en) return;
        old_cnt = q.size();
        commit  = head_commits();
        flush   = commit && m_jmp[q[0]];
        if (iRF_En && !flush) begin
            e_rs_en = 1;
            resolve(iRF_Qs1, iRF_Vs1, e_qj, e_vj);
            resolve(iRF_Qs2, iRF_Vs2, e_qk, e_vk);
            e_qd = iRF_Qd; e_op = iRF_Op; e_pc = iRF_Pc; e_imm = iRF_Imm;
        end
        h = commit ? q[0] : 0;
        if (commit) begin
            e_rf_en = (m_rd[h] != 0);
            e_rd    = m_rd[h];
            e_vd    = m_val[h];
            if (m_jmp[h]) begin
                e_mp   = 1;
                e_mppc = m_tgt[h];
            end
        end
        if (iCDB_En) begin
            m_val[iCDB_Tag]   = iCDB_Val;
            m_tgt[iCDB_Tag]   = iCDB_Tgt;
            m_jmp[iCDB_Tag]   = iCDB_Jmp;
            m_ready[iCDB_Tag] = 1;
        end
        if (iRF_En) begin
            m_rd[iRF_Qd]     = iRF_Rd;
            m_filled[iRF_Qd] = 1;
        end
        if (iIS_En && old_cnt < S - 1) begin
            q.push_back(m_tail);
            clear_entry(m_tail);
            m_tail = wrap_next(m_tail);
        end
        if (commit) begin
            clear_entry(h);
            void'(q.pop_front());
        end
        if (flush) begin
            for (int i = 0; i < S; i++) clear_entry(i);
            q.delete();
            m_tail = 1;
        end
    endtask

    function automatic logic [AW-1:0] pick_src();
        if (q.size() == 0 || $urandom_range(0, 1) == 0) return '0;
        return AW'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    task automatic gen(input int p_is, input int p_cdb, input bit p_rst);
        int  cand[$];
        bit  head_flush;
        rst      = p_rst && ($urandom_range(0, 299) == 0);
        en       = ($urandom_range(0, 9) != 0);
        iIS_En   = 0;
        iRF_En   = 0;
        iCDB_En  = 0;
        iCDB_Jmp = 0;
        iRF_Qd   = '0;
        iRF_Qs1  = '0;
        iRF_Qs2  = '0;
        iCDB_Tag = '0;
        iRF_Rd   = RW'($urandom);
        iRF_Vs1  = $urandom;
        iRF_Vs2  = $urandom;
        iRF_Op   = OW'($urandom);
        iRF_Pc   = $urandom;
        iRF_Imm  = $urandom;
        iCDB_Val = $urandom;
        iCDB_Tgt = $urandom;
        if (rst || !en) return;
        head_flush = head_commits() && m_jmp[q[0]];
        if (pending_vld) begin
            if (!head_flush) begin
                iRF_En  = 1;
                iRF_Qd  = pending_tag;
                iRF_Qs1 = pick_src();
                iRF_Qs2 = pick_src();
            end
            pending_vld = 0;
        end
        if ($urandom_range(0, 99) < ((q.size() >= S - 2) ? 15 : p_is)) begin
            iIS_En = 1;
            if (q.size() < S - 1 && !head_flush) begin
                pending_vld = 1;
                pending_tag = AW'(m_tail);
            end
        end
        if ($urandom_range(0, 99) < p_cdb) begin
            foreach (q[i]) if (m_filled[q[i]] && !m_ready[q[i]]) cand.push_back(q[i]);
            if (cand.size() > 0) begin
                iCDB_En  = 1;
                iCDB_Tag = AW'(cand[$urandom_range(0, cand.size() - 1)]);
                iCDB_Jmp = ($urandom_range(0, 9) == 0);
            end
        end
    endtask

    task automatic compare_all();
        chk("rf_qn",   32'(oRF_Qn),   rst ? 32'd0 : 32'(m_tail));
        chk("is_full", 32'(oIS_Full), 32'(!rst && q.size() >= S - 2));
        chk("rs_en",   32'(oRS_En),   32'(e_rs_en));
        chk("rs_qj",   32'(oRS_Qj),   32'(e_qj));
        chk("rs_qk",   32'(oRS_Qk),   32'(e_qk));
        chk("rs_vj",   oRS_Vj,        e_vj);
        chk("rs_vk",   oRS_Vk,        e_vk);
        chk("rs_qd",   32'(oRS_Qd),   32'(e_qd));
        chk("rs_op",   32'(oRS_Op),   32'(e_op));
        chk("rs_pc",   oRS_Pc,        e_pc);
        chk("rs_imm",  oRS_Imm,       e_imm);
        chk("rf_en",   32'(oRF_En),   32'(e_rf_en));
        chk("rf_rd",   32'(oRF_Rd),   32'(e_rd));
        chk("rf_vd",   oRF_Vd,        e_vd);
        chk("mp",      32'(oMp),      32'(e_mp));
        chk("mp_pc",   oMp_Pc,        e_mppc);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (rst) pending_vld = 0;
    endtask

    // Phases: balanced traffic, fill-to-full with rare results, drain, then resets and stalls mixed in.
    int ph_is  [4] = '{60, 95, 35, 70};
    int ph_cdb [4] = '{50, 8,  90, 45};
    bit ph_rst [4] = '{0,  0,  0,  1};

    initial begin
        pending_vld = 0;
        pending_tag = '0;
        m_tail      = 1;
        en = 1; iIS_En = 0; iRF_En = 0; iCDB_En = 0; iCDB_Jmp = 0;
        iRF_Qd = '0; iRF_Rd = '0; iRF_Qs1 = '0; iRF_Qs2 = '0;
        iRF_Vs1 = '0; iRF_Vs2 = '0; iRF_Op = '0; iRF_Pc = '0; iRF_Imm = '0;
        iCDB_Tag = '0; iCDB_Val = '0; iCDB_Tgt = '0;
        rst = 1;
        repeat (2) cycle();
        rst = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 1500; c++) begin
                gen(ph_is[p], ph_cdb[p], ph_rst[p]);
                cycle();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
